// File: rtl/tlp_pkg.sv
// Shared TLP link constants: framing symbols, size limit, framer state encoding and TLP type codes.
package tlp_pkg;

  localparam int unsigned MAX_BYTES = 20;

  localparam logic [7:0] STP_SYM  = 8'hFB;
  localparam logic [7:0] END_SYM  = 8'hFD;
  localparam logic [7:0] EDB_SYM  = 8'hFE;
  localparam logic [7:0] IDLE_SYM = 8'h00;

  // EDB is only reachable when the abort path is built in.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    STP  = 3'd1,
    DATA = 3'd2,
    END  = 3'd3,
    EDB  = 3'd4
  } tlp_state_e;

  typedef enum logic [7:0] {
    TLP_MRD  = 8'h00,
    TLP_MWR  = 8'h40,
    TLP_CPL  = 8'h0A,
    TLP_CPLD = 8'h4A
  } tlp_type_e;

endpackage

// File: rtl/tlp_byte_sel.sv
// Combinational byte mux: picks byte[idx] of the capture register, byte 0 in the top bits.
module tlp_byte_sel #(
  parameter int unsigned MAX_BYTES = tlp_pkg::MAX_BYTES,
  parameter int unsigned IDX_W     = 5
) (
  input  logic [8*MAX_BYTES-1:0] cap,
  input  logic [IDX_W-1:0]       idx,
  output logic [7:0]             byte_out
);

  always_comb begin
    byte_out = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if (idx == IDX_W'(i)) byte_out = cap[8*(MAX_BYTES-1-i) +: 8];
    end
  end

endmodule

// File: rtl/tlp_framer.sv
// Serialises one buffered TLP onto the 8-bit symbol lane as STP, payload (MSB-first), END.
// Optional EDB abort path enabled by defining TLP_FRAMER_ABORT_EN.
module tlp_framer #(
  parameter int unsigned MAX_BYTES = tlp_pkg::MAX_BYTES,
  parameter logic [7:0]  STP_SYM   = tlp_pkg::STP_SYM,
  parameter logic [7:0]  END_SYM   = tlp_pkg::END_SYM,
  parameter logic [7:0]  IDLE_SYM  = tlp_pkg::IDLE_SYM
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [8*MAX_BYTES-1:0] tlp_in,
  input  logic [4:0]             tlp_len,
  input  logic                   tlp_valid,
`ifdef TLP_FRAMER_ABORT_EN
  input  logic                   tx_abort,
`endif
  output logic                   tlp_ready,
  output logic [7:0]             data_out,
  output logic                   datak_out,
  output logic                   tx_busy,
  output logic [3:0]             tlp_sent_count,
  output logic                   len_err
);
  import tlp_pkg::*;

  localparam int unsigned IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

  tlp_state_e             state;
  logic [IDX_W-1:0]       idx;
  logic [8*MAX_BYTES-1:0] cap;
  logic [4:0]             len_q;
  logic [7:0]             cur_byte;
  logic                   hs;
  logic                   len_ok;
  logic                   last_byte;
  logic                   abort;

  assign tlp_ready = (state == IDLE) || (state == END);
  assign hs        = tlp_valid && tlp_ready;
  assign len_ok    = (tlp_len != '0) && (32'(tlp_len) <= MAX_BYTES);
  assign last_byte = (32'(idx) + 32'd1) == 32'(len_q);

`ifdef TLP_FRAMER_ABORT_EN
  assign abort = tx_abort && ((state == STP) || (state == DATA));
`else
  assign abort = 1'b0;
`endif

  tlp_byte_sel #(
    .MAX_BYTES(MAX_BYTES),
    .IDX_W    (IDX_W)
  ) u_byte_sel (
    .cap     (cap),
    .idx     (idx),
    .byte_out(cur_byte)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
      cap   <= '0;
      len_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hs && len_ok) begin
            state <= STP;
            cap   <= tlp_in;
            len_q <= tlp_len;
          end
        end
        STP: begin
          state <= abort ? EDB : DATA;
          idx   <= '0;
        end
        DATA: begin
          if (abort)          state <= EDB;
          else if (last_byte) state <= END;
          else                idx   <= idx + IDX_W'(1);
        end
        END: begin
          if (hs && len_ok) begin
            state <= STP;
            cap   <= tlp_in;
            len_q <= tlp_len;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Lane outputs are a registered decode of the state, so each symbol trails its state by one cycle;
  // an abort overrides that decode so EDB replaces the symbol that would have come next.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out       <= IDLE_SYM;
      datak_out      <= 1'b0;
      tx_busy        <= 1'b0;
      tlp_sent_count <= '0;
      len_err        <= 1'b0;
    end else begin
      len_err <= hs && !len_ok;
      tx_busy <= (state == STP) || (state == DATA) || (state == END);
      if (abort) begin
        data_out  <= EDB_SYM;
        datak_out <= 1'b1;
      end else begin
        case (state)
          STP: begin
            data_out  <= STP_SYM;
            datak_out <= 1'b1;
          end
          DATA: begin
            data_out  <= cur_byte;
            datak_out <= 1'b0;
          end
          END: begin
            data_out       <= END_SYM;
            datak_out      <= 1'b1;
            tlp_sent_count <= tlp_sent_count + 4'd1;
          end
          default: begin
            data_out  <= IDLE_SYM;
            datak_out <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tlp_framer.sv
// Directed self-checking bench for tlp_framer; the abort scenario is built when TLP_FRAMER_ABORT_EN is defined.
module tb_tlp_framer;

  logic         clk;
  logic         reset;
  logic [159:0] tlp_in;
  logic [4:0]   tlp_len;
  logic         tlp_valid;
`ifdef TLP_FRAMER_ABORT_EN
  logic         tx_abort;
`endif
  logic         tlp_ready;
  logic [7:0]   data_out;
  logic         datak_out;
  logic         tx_busy;
  logic [3:0]   tlp_sent_count;
  logic         len_err;

  int vectors     = 0;
  int miscompares = 0;
  int exp_cnt     = 0;

  tlp_framer #(
    .MAX_BYTES(20),
    .STP_SYM  (8'hFB),
    .END_SYM  (8'hFD),
    .IDLE_SYM (8'h00)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .tlp_in        (tlp_in),
    .tlp_len       (tlp_len),
    .tlp_valid     (tlp_valid),
`ifdef TLP_FRAMER_ABORT_EN
    .tx_abort      (tx_abort),
`endif
    .tlp_ready     (tlp_ready),
    .data_out      (data_out),
    .datak_out     (datak_out),
    .tx_busy       (tx_busy),
    .tlp_sent_count(tlp_sent_count),
    .len_err       (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_lane(input string tag, input logic [7:0] d, input logic k);
    chk({tag, " data"}, 32'(data_out), 32'(d));
    chk({tag, " k"}, 32'(datak_out), 32'(k));
  endtask

  // Expects STP, len payload bytes MSB-first, then END with the count advanced.
  task automatic expect_frame(input string tag, input logic [159:0] img, input int len);
    step();
    chk_lane({tag, " stp"}, 8'hFB, 1'b1);
    chk({tag, " busy stp"}, 32'(tx_busy), 32'd1);
    for (int i = 0; i < len; i++) begin
      step();
      chk_lane($sformatf("%s byte%0d", tag, i), img[159-8*i -: 8], 1'b0);
    end
    step();
    chk_lane({tag, " end"}, 8'hFD, 1'b1);
    chk({tag, " busy end"}, 32'(tx_busy), 32'd1);
    exp_cnt = (exp_cnt + 1) % 16;
    chk({tag, " count"}, 32'(tlp_sent_count), 32'(exp_cnt));
  endtask

  logic [159:0] img;
  logic [159:0] img2;

  initial begin
    reset     = 1'b0;
    tlp_in    = '0;
    tlp_len   = '0;
    tlp_valid = 1'b0;
`ifdef TLP_FRAMER_ABORT_EN
    tx_abort  = 1'b0;
`endif
    #11;
    chk_lane("reset", 8'h00, 1'b0);
    chk("reset busy", 32'(tx_busy), 32'd0);
    chk("reset count", 32'(tlp_sent_count), 32'd0);
    chk("reset len_err", 32'(len_err), 32'd0);
    #1 reset = 1'b1;
    step();
    chk("idle ready", 32'(tlp_ready), 32'd1);
    chk_lane("idle", 8'h00, 1'b0);

    // Single 4-byte frame; inputs are scrambled after capture.
    img = '0;
    img[159:128] = 32'h11110211;
    tlp_in = img; tlp_len = 5'd4; tlp_valid = 1'b1;
    step();
    tlp_valid = 1'b0; tlp_in = '1; tlp_len = 5'd0;
    chk_lane("f1 pre", 8'h00, 1'b0);
    chk("f1 ready busy", 32'(tlp_ready), 32'd0);
    expect_frame("f1", img, 4);
    step();
    chk_lane("f1 post", 8'h00, 1'b0);
    chk("f1 busy post", 32'(tx_busy), 32'd0);

    // Back-to-back: 20 x 0x33 then AABB0411, valid held into the first END.
    img = {20{8'h33}};
    img2 = '0;
    img2[159:128] = 32'hAABB0411;
    tlp_in = img; tlp_len = 5'd20; tlp_valid = 1'b1;
    step();
    tlp_in = img2; tlp_len = 5'd4;
    expect_frame("b2b1", img, 20);
    tlp_valid = 1'b0;
    expect_frame("b2b2", img2, 4);
    step();
    chk_lane("b2b post", 8'h00, 1'b0);

    // Illegal lengths.
    tlp_len = 5'd0; tlp_valid = 1'b1;
    step();
    tlp_valid = 1'b0;
    chk("len0 err", 32'(len_err), 32'd1);
    chk_lane("len0", 8'h00, 1'b0);
    step();
    chk("len0 err clr", 32'(len_err), 32'd0);
    chk_lane("len0 after", 8'h00, 1'b0);
    tlp_len = 5'd21; tlp_valid = 1'b1;
    step();
    tlp_valid = 1'b0;
    chk("len21 err", 32'(len_err), 32'd1);
    chk("len21 ready", 32'(tlp_ready), 32'd1);
    step();
    chk("len21 err clr", 32'(len_err), 32'd0);
    chk_lane("len21 after", 8'h00, 1'b0);
    chk("len err count", 32'(tlp_sent_count), 32'(exp_cnt));

    // Count wrap after 16 one-byte frames from a fresh reset.
    #2 reset = 1'b0;
    #1 chk("wrap reset count", 32'(tlp_sent_count), 32'd0);
    #1 reset = 1'b1;
    exp_cnt = 0;
    for (int n = 0; n < 16; n++) begin
      img = '0;
      img[159:152] = 8'(n + 8'h40);
      tlp_in = img; tlp_len = 5'd1; tlp_valid = 1'b1;
      step();
      tlp_valid = 1'b0;
      expect_frame($sformatf("wrap%0d", n), img, 1);
    end
    chk("wrap final count", 32'(tlp_sent_count), 32'd0);
    step();

    // Reset mid-frame while byte 2 of a 10-byte frame is on the lane.
    img = '0;
    img[159:80] = 80'h0102030405060708090A;
    tlp_in = img; tlp_len = 5'd10; tlp_valid = 1'b1;
    step();
    tlp_valid = 1'b0;
    step();
    chk_lane("mid stp", 8'hFB, 1'b1);
    step(); step(); step();
    chk_lane("mid byte2", 8'h03, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk_lane("mid reset", 8'h00, 1'b0);
    chk("mid reset busy", 32'(tx_busy), 32'd0);
    chk("mid reset count", 32'(tlp_sent_count), 32'd0);
    #2 reset = 1'b1;
    exp_cnt = 0;
    for (int n = 0; n < 12; n++) begin
      step();
      chk_lane($sformatf("mid quiet%0d", n), 8'h00, 1'b0);
    end
    img = '0;
    img[159:144] = 16'hC35A;
    tlp_in = img; tlp_len = 5'd2; tlp_valid = 1'b1;
    step();
    tlp_valid = 1'b0;
    expect_frame("mid next", img, 2);
    step();

`ifdef TLP_FRAMER_ABORT_EN
    // Abort while byte 3 is on the lane: EDB follows, then idle, count held.
    img = '0;
    img[159:96] = 64'h2122232425262728;
    tlp_in = img; tlp_len = 5'd8; tlp_valid = 1'b1;
    step();
    tlp_valid = 1'b0;
    step();
    chk_lane("abt stp", 8'hFB, 1'b1);
    step(); step(); step(); step();
    chk_lane("abt byte3", 8'h24, 1'b0);
    tx_abort = 1'b1;
    tlp_valid = 1'b1; tlp_len = 5'd1;
    step();
    tx_abort = 1'b0;
    chk_lane("abt edb", 8'hFE, 1'b1);
    chk("abt edb ready", 32'(tlp_ready), 32'd0);
    tlp_valid = 1'b0;
    step();
    chk_lane("abt idle", 8'h00, 1'b0);
    chk("abt count", 32'(tlp_sent_count), 32'(exp_cnt));
    step();
    chk_lane("abt idle2", 8'h00, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
